// File: rtl/fpu_mem_pkg.sv
// Shared widths and drainer state encoding for the FPU write-buffer drain path.
package fpu_mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_e;

endpackage

// File: rtl/fpu_col_packer.sv
// Assembles one column of bytes into a 64-bit memory word, one byte lane per row.
module fpu_col_packer
  import fpu_mem_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int ROW_BITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  cap_en,
  input  logic [ROW_BITS-1:0]   cap_row,
  input  logic [7:0]            cap_data,
  output logic [MEM_DATA_W-1:0] word
);

  logic [MEM_DATA_W-1:0] word_q, word_d;

  // Lanes at or above ROWS are never written, so they stay zero after a clear.
  always_comb begin
    word_d = word_q;
    if (clear) begin
      word_d = '0;
    end else if (cap_en) begin
      for (int r = 0; r < ROWS; r++) begin
        if (cap_row == ROW_BITS'(r)) begin
          word_d[r*8 +: 8] = cap_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/fpu_write_drainer.sv
// Drains the FPU column write buffer to memory, one 64-bit word per column.
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | reading R rows of the current column, plus one cycle for the last byte
//   SEND  | presenting the packed column word until mem_wr_ready
//   DONE  | one-cycle done pulse, then back to IDLE
module fpu_write_drainer
  import fpu_mem_pkg::*;
#(
  parameter  int COL_WIDTH        = 10,
  parameter  int MEM_BUFFER_WIDTH = 512,
  localparam int ROWS             = COL_WIDTH - 2,
  localparam int BADDR_BITS       = (MEM_BUFFER_WIDTH > 1) ? $clog2(MEM_BUFFER_WIDTH) : 1,
  localparam int WADDR_BITS       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [MEM_ADDR_W-1:0]            base_addr,
  input  logic [BADDR_BITS:0]              num_cols,
  output logic                             busy,
  output logic                             done,
  output logic                             buf_rd_en,
  output logic [BADDR_BITS+WADDR_BITS-1:0] buf_rd_addr,
  input  logic [7:0]                       buf_rd_data,
  output logic                             mem_wr_valid,
  input  logic                             mem_wr_ready,
  output logic [MEM_ADDR_W-1:0]            mem_wr_addr,
  output logic [MEM_DATA_W-1:0]            mem_wr_data,
  output logic                             mem_wr_last
);

  if (ROWS > 8 || ROWS < 1) begin : g_bad_col_width
    $error("fpu_write_drainer: COL_WIDTH-2 must be in 1..8");
  end

  localparam logic [BADDR_BITS:0] COL_ONE = (BADDR_BITS+1)'(1);
  localparam logic [WADDR_BITS:0] ROW_ONE = (WADDR_BITS+1)'(1);
  localparam logic [WADDR_BITS:0] ROW_END = (WADDR_BITS+1)'(ROWS);

  drain_state_e            state_q, state_d;
  logic [BADDR_BITS:0]     col_q, col_d;
  logic [BADDR_BITS:0]     num_q, num_d;
  logic [MEM_ADDR_W-1:0]   base_q, base_d;
  logic [WADDR_BITS:0]     row_q, row_d;
  logic                    cap_vld_q, cap_vld_d;
  logic [WADDR_BITS-1:0]   cap_row_q, cap_row_d;
  logic                    pk_clear;
  logic                    last_col;

  assign last_col = ((col_q + COL_ONE) == num_q);

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    num_d        = num_q;
    base_d       = base_q;
    row_d        = row_q;
    cap_vld_d    = 1'b0;
    cap_row_d    = '0;
    pk_clear     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    buf_rd_en    = 1'b0;
    buf_rd_addr  = '0;
    mem_wr_valid = 1'b0;
    mem_wr_addr  = '0;
    mem_wr_last  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d   = base_addr;
          num_d    = num_cols;
          col_d    = '0;
          row_d    = '0;
          pk_clear = 1'b1;
          state_d  = (num_cols == '0) ? ST_DONE : ST_FETCH;
        end
      end

      ST_FETCH: begin
        busy = 1'b1;
        if (row_q < ROW_END) begin
          buf_rd_en   = 1'b1;
          buf_rd_addr = {col_q[BADDR_BITS-1:0], row_q[WADDR_BITS-1:0]};
          cap_vld_d   = 1'b1;
          cap_row_d   = row_q[WADDR_BITS-1:0];
          row_d       = row_q + ROW_ONE;
        end else begin
          // Last byte lands in the packer on this edge.
          state_d = ST_SEND;
        end
      end

      ST_SEND: begin
        busy         = 1'b1;
        mem_wr_valid = 1'b1;
        mem_wr_addr  = base_q + (MEM_ADDR_W'(col_q) << 3);
        mem_wr_last  = last_col;
        if (mem_wr_ready) begin
          if (last_col) begin
            state_d = ST_DONE;
          end else begin
            col_d    = col_q + COL_ONE;
            row_d    = '0;
            pk_clear = 1'b1;
            state_d  = ST_FETCH;
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      num_q     <= '0;
      base_q    <= '0;
      row_q     <= '0;
      cap_vld_q <= 1'b0;
      cap_row_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      num_q     <= num_d;
      base_q    <= base_d;
      row_q     <= row_d;
      cap_vld_q <= cap_vld_d;
      cap_row_q <= cap_row_d;
    end
  end

  fpu_col_packer #(
    .ROWS     (ROWS),
    .ROW_BITS (WADDR_BITS)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (pk_clear),
    .cap_en   (cap_vld_q),
    .cap_row  (cap_row_q),
    .cap_data (buf_rd_data),
    .word     (mem_wr_data)
  );

endmodule
